// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared types and helpers for the 3x3 convolution frame sequencer.
//   state_t     : frame sequencer states
//   prime_beats : beats needed before the first window centre exists (WIDTH+1)
//   frame_pix   : pixels in one frame (WIDTH*HEIGHT)
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int prime_beats(input int width);
        return width + 1;
    endfunction

    function automatic int frame_pix(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/dstream.sv
// ---------------------------------------------------------------------------
// dstream
//   Valid/ready/data stream bundle.
//   valid : producer has a beat
//   ready : consumer takes the beat
//   data  : W-bit payload
//   Modport "in" is the consumer side, "out" the producer side.
// ---------------------------------------------------------------------------
interface dstream #(
    parameter int W = 30
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport in  (input valid, input data, output ready);
    modport out (output valid, output data, input ready);
endinterface

// File: rtl/conv_frame_ctrl_pos.sv
// ---------------------------------------------------------------------------
// pixel_pos_counter
//   Raster position counter: col wraps WIDTH-1 -> 0 and bumps row; row wraps
//   HEIGHT-1 -> 0.
//   clk, reset : clock, async active-high reset
//   clr        : synchronous clear to (0,0)
//   en         : advance one position
//   row, col   : current position
//   last       : position is (HEIGHT-1, WIDTH-1)
// ---------------------------------------------------------------------------
module pixel_pos_counter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      en,
    output logic [$clog2(HEIGHT)-1:0] row,
    output logic [$clog2(WIDTH)-1:0]  col,
    output logic                      last
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);

    logic col_end;
    logic row_end;

    assign col_end = (col == CW'(WIDTH - 1));
    assign row_end = (row == RW'(HEIGHT - 1));
    assign last    = col_end & row_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/conv_frame_ctrl.sv
// ---------------------------------------------------------------------------
// conv_frame_ctrl
//   Frame sequencer for the 3x3 line-buffer convolution datapath. Passes one
//   frame of pixels through, then injects WIDTH+1 zero beats so every centre
//   pixel gets produced, and tags each output beat with its window centre.
//   clk, reset  : clock, async active-high reset
//   start       : arm one frame (only looked at in IDLE)
//   x           : pixel stream from source
//   y           : pixel stream to conv datapath
//   win_valid   : beat's centre is an interior pixel
//   border      : primed beat whose centre lies on the frame edge
//   sof         : beat's centre is (0,0)
//   eol         : beat's centre is in the last column
//   c_row,c_col : centre position of the current beat
//   busy        : STREAM or FLUSH
//   frame_done  : one-cycle pulse in DONE
// ---------------------------------------------------------------------------
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int W      = 30,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    dstream.in                        x,
    dstream.out                       y,
    output logic                      win_valid,
    output logic                      border,
    output logic                      sof,
    output logic                      eol,
    output logic [$clog2(HEIGHT)-1:0] c_row,
    output logic [$clog2(WIDTH)-1:0]  c_col,
    output logic                      busy,
    output logic                      frame_done
);
    localparam int RW        = $clog2(HEIGHT);
    localparam int CW        = $clog2(WIDTH);
    localparam int PRIME     = prime_beats(WIDTH);
    localparam int LAST_BEAT = frame_pix(WIDTH, HEIGHT) + WIDTH;
    // One spare count so the increment after the final beat cannot wrap.
    localparam int BW        = $clog2(LAST_BEAT + 2);

    state_t         state;
    state_t         state_nxt;
    logic [BW-1:0]  beat;
    logic           move;
    logic           primed;
    logic           qual;
    logic           interior;
    logic           y_vld;
    logic [W-1:0]   y_dat;
    logic           x_rdy;
    logic           clr;
    logic           in_en;
    logic           c_en;
    logic           in_last;
    logic           c_last;
    logic [RW-1:0]  in_row;
    logic [CW-1:0]  in_col;
    logic           unused_in_pos;

    // Decoded straight from state so the handshake outputs never feed back
    // into their own next-state logic.
    assign move = ((state == STREAM) & x.valid & y.ready) |
                  ((state == FLUSH) & y.ready);

    assign primed = (beat >= BW'(PRIME));
    assign clr    = (state == IDLE);
    assign in_en  = move & (state == STREAM);
    assign c_en   = move & primed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        y_vld     = 1'b0;
        y_dat     = '0;
        x_rdy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                y_vld = x.valid;
                y_dat = x.data;
                x_rdy = y.ready;
                if (move && in_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                y_vld = 1'b1;
                // The final flush beat is the one whose centre is the last pixel.
                if (move && c_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign y.valid = y_vld;
    assign y.data  = y_dat;
    assign x.ready = x_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (move) begin
            beat <= beat + BW'(1);
        end
    end

    pixel_pos_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_in_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .en   (in_en),
        .row  (in_row),
        .col  (in_col),
        .last (in_last)
    );

    pixel_pos_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_c_pos (
        .clk  (clk),
        .reset(reset),
        .clr  (clr),
        .en   (c_en),
        .row  (c_row),
        .col  (c_col),
        .last (c_last)
    );

    // Input position is only needed for its wrap flag.
    assign unused_in_pos = ^{in_row, in_col};

    assign qual     = y_vld & primed;
    assign interior = (c_row != '0) && (c_row <= RW'(HEIGHT - 2)) &&
                      (c_col != '0) && (c_col <= CW'(WIDTH - 2));

    assign win_valid  = qual & interior;
    assign border     = qual & ~interior;
    assign sof        = qual & (c_row == '0) & (c_col == '0);
    assign eol        = qual & (c_col == CW'(WIDTH - 1));
    assign busy       = (state == STREAM) | (state == FLUSH);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_conv_frame_ctrl.sv
module tb_conv_frame_ctrl;
    localparam int W      = 8;
    localparam int WIDTH  = 5;
    localparam int HEIGHT = 5;
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int NB     = NPIX + WIDTH + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       win_valid, border, sof, eol, busy, frame_done;
    logic [2:0] c_row, c_col;

    dstream #(.W(W)) xs ();
    dstream #(.W(W)) ys ();

    conv_frame_ctrl #(
        .W     (W),
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .x         (xs),
        .y         (ys),
        .win_valid (win_valid),
        .border    (border),
        .sof       (sof),
        .eol       (eol),
        .c_row     (c_row),
        .c_col     (c_col),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         win;
        logic         brd;
        logic         sof;
        logic         eol;
        logic [2:0]   row;
        logic [2:0]   col;
    } beat_t;

    beat_t   tbl [NB];
    logic [7:0] pix_in [NB];

    int checks = 0;
    int failures = 0;

    int win_cnt, first_win, last_win, sof_cnt, sof_beat, done_cnt, beats_at_done;
    logic [NB-1:0] eol_mask;
    logic [NB-1:0] eol_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t act_beat();
        beat_t a;
        a.data = ys.data;
        a.win  = win_valid;
        a.brd  = border;
        a.sof  = sof;
        a.eol  = eol;
        a.row  = c_row;
        a.col  = c_col;
        return a;
    endfunction

    task automatic run_frame(input bit stall, input bit poke, input int stop_at);
        int beat;
        int cyc;
        int since;
        beat = 0; cyc = 0; since = 0;
        win_cnt = 0; first_win = -1; last_win = -1; sof_cnt = 0; sof_beat = -1;
        eol_mask = '0; done_cnt = 0; beats_at_done = -1;
        xs.valid = 1'b0; ys.ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < 600 && since < 3) begin
            xs.valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            ys.ready = stall ? (cyc % 2 == 0) : 1'b1;
            xs.data  = (beat < NPIX) ? pix_in[beat] : 8'h00;
            start    = poke && (beat == 3 || beat == NPIX + 2);
            #3;
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) beats_at_done = beat;
            end
            if (done_cnt > 0) since++;
            if (busy && beat < NPIX) chk("xready_eq_yready", 32'(xs.ready), 32'(ys.ready));
            if (ys.valid && ys.ready) begin
                if (beat < NB) begin
                    chk($sformatf("beat%0d", beat), 32'(act_beat()), 32'(tbl[beat]));
                    if (win_valid) begin
                        win_cnt++;
                        if (first_win < 0) first_win = beat;
                        last_win = beat;
                    end
                    if (sof) begin
                        sof_cnt++;
                        sof_beat = beat;
                    end
                    if (eol) eol_mask[beat] = 1'b1;
                end else begin
                    chk("extra_beat", 32'(beat), 32'(NB - 1));
                end
                beat++;
            end
            @(posedge clk); #1;
            cyc++;
            if (stop_at >= 0 && beat >= stop_at) break;
        end
        start = 1'b0; xs.valid = 1'b0; ys.ready = 1'b0;
        if (stop_at < 0) begin
            chk("frame_done_pulses", 32'(done_cnt), 32'd1);
            chk("beats_at_done", 32'(beats_at_done), 32'(NB));
            chk("busy_after_frame", 32'(busy), 32'd0);
        end
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_win_cnt"}, 32'(win_cnt), 32'd9);
        chk({tag, "_first_win"}, 32'(first_win), 32'd12);
        chk({tag, "_last_win"}, 32'(last_win), 32'd24);
        chk({tag, "_sof_cnt"}, 32'(sof_cnt), 32'd1);
        chk({tag, "_sof_beat"}, 32'(sof_beat), 32'd6);
        chk({tag, "_eol_mask"}, 32'(eol_mask), 32'(eol_exp));
    endtask

    initial begin
        int extra;
        int idx, r, c;
        bit pr;

        // Expected per-beat record: centre index = beat - (WIDTH+1).
        for (int b = 0; b < NB; b++) begin
            pix_in[b] = (b < NPIX) ? 8'(b + 1) : 8'h00;
            pr  = (b >= WIDTH + 1);
            idx = b - (WIDTH + 1);
            r   = pr ? idx / WIDTH : 0;
            c   = pr ? idx % WIDTH : 0;
            tbl[b].data = pix_in[b];
            tbl[b].win  = pr && r >= 1 && r <= HEIGHT - 2 && c >= 1 && c <= WIDTH - 2;
            tbl[b].brd  = pr && !tbl[b].win;
            tbl[b].sof  = pr && r == 0 && c == 0;
            tbl[b].eol  = pr && c == WIDTH - 1;
            tbl[b].row  = 3'(r);
            tbl[b].col  = 3'(c);
        end
        eol_exp = '0;
        eol_exp[10] = 1'b1; eol_exp[15] = 1'b1; eol_exp[20] = 1'b1;
        eol_exp[25] = 1'b1; eol_exp[30] = 1'b1;

        // Reset state, with the source and sink both willing.
        xs.valid = 1'b1; ys.ready = 1'b1; xs.data = 8'h55;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_yvalid", 32'(ys.valid), 32'd0);
        chk("rst_xready", 32'(xs.ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_flags", 32'({win_valid, border, sof, eol}), 32'd0);
        chk("rst_pos", 32'({c_row, c_col}), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #4;
        chk("idle_yvalid", 32'(ys.valid), 32'd0);
        chk("idle_xready", 32'(xs.ready), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Free-running frame.
        run_frame(1'b0, 1'b0, -1);
        chk_stats("free");

        // Backpressure + source bubbles.
        @(posedge clk); #1;
        run_frame(1'b1, 1'b0, -1);
        chk_stats("stall");

        // Abort after beat 10, then a clean replay.
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, 11);
        xs.valid = 1'b1; ys.ready = 1'b1;
        #1;
        chk("pre_abort_yvalid", 32'(ys.valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_yvalid", 32'(ys.valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_xready", 32'(xs.ready), 32'd0);
        #2;
        reset = 1'b0;
        xs.valid = 1'b0; ys.ready = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, 1'b0, -1);
        chk_stats("replay");

        // start pokes inside STREAM and FLUSH must not launch a second frame.
        @(posedge clk); #1;
        run_frame(1'b0, 1'b1, -1);
        extra = 0;
        xs.valid = 1'b1; ys.ready = 1'b1;
        repeat (8) begin
            @(posedge clk); #4;
            if (frame_done || busy) extra++;
        end
        chk("no_second_frame", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
